uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, BPS_PARA clocks per bit, LSB first.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx #(
    parameter int BPS_PARA = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    localparam logic [12:0] LP_BIT_LAST = 13'(BPS_PARA - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_done;
    logic        w_txd_next;
    logic        w_done_next;
    logic        w_bit_end;
    logic        w_accept;
    logic        w_cnt_clr;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    assign tx_ready  = (r_state == S_IDLE);
    assign tx_busy   = ~tx_ready;
    assign tx_done   = r_done;
    assign txd       = r_txd;

    assign w_accept  = tx_start && tx_ready;
    assign w_bit_end = (r_baud_cnt == LP_BIT_LAST);
    // Counter restarts at every bit boundary and whenever the FSM is
    // (or is about to be) idle, so each bit gets a full BPS_PARA cycles.
    assign w_cnt_clr = (r_state == S_IDLE) || w_bit_end ||
                       (w_state_next == S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, plus the line level and done flag for the next cycle.
    always_comb begin
        w_state_next = r_state;
        w_txd_next   = r_txd;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_next = 1'b1;
                if (tx_start) begin
                    w_state_next = S_START;
                    w_txd_next   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_txd_next   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
                        w_txd_next   = r_parity;
`else
                        w_state_next = S_STOP;
                        w_txd_next   = 1'b1;
`endif
                    end else begin
                        w_txd_next = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_txd_next   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                w_txd_next = 1'b1;
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_txd_next   = 1'b1;
            end
        endcase
    end

    // Registered line output and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txd  <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_done <= w_done_next;
        end
    end

    // Baud counter: 0..BPS_PARA-1 within each bit, held at 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= 13'd0;
        end else if (w_cnt_clr) begin
            r_baud_cnt <= 13'd0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
        end
    end

    // Data bit index; wraps 7->0 as the last data bit ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
        end else if (r_state != S_DATA) begin
            r_bit_idx <= 3'd0;
        end else if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
        end
    end

    // Byte latched on accept, shifted right so bit 0 is always on deck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 8'd0;
        end else if (w_accept) begin
            r_shift <= tx_data;
        end else if (r_state == S_DATA && w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the latched byte; computed once since the
    // shift register no longer holds all bits by the parity slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^tx_data;
        end
    end
`endif

endmodule
